// File: rtl/clkgen_sched.sv
// Multi-channel clock-enable scheduler: per-channel toggle limits, idle/run/step sequencing,
// square outputs and tick pulses. Define CLKGEN_SCHED_TICKCNT_EN to enable the tick_cnt counter.
module clkgen_sched #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned CW        = 32,
  parameter int unsigned DEF_LIMIT = 1
) (
  input  logic           clkin,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [2:0]     cfg_ch,
  input  logic [CW-1:0]  cfg_limit,
  input  logic           run,
  input  logic           step,
  input  logic [NCH-1:0] ch_en,
  output logic [NCH-1:0] clkout,
  output logic [NCH-1:0] tick,
  output logic           busy,
  output logic [15:0]    tick_cnt
);

  localparam logic [CW-1:0] DefLimit = CW'(DEF_LIMIT);

  typedef enum logic [1:0] {StIdle, StRun, StStep} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q   [NCH];
  logic [CW-1:0]   cnt_d   [NCH];
  logic [CW-1:0]   limit_q [NCH];
  logic [CW-1:0]   limit_d [NCH];
  logic [NCH-1:0]  clk_q, clk_d;
  logic [NCH-1:0]  tick_q, tick_d;
  logic            busy_q;
  logic            pend_q, pend_d;
  logic [2:0]      pend_ch_q, pend_ch_d;
  logic [CW-1:0]   pend_lim_q, pend_lim_d;

  logic accept, ch_ok, to_idle, write_direct, write_pend, counting, pend_hit;

  // cnt+1 is formed in CW+1 bits so a limit of all-ones cannot overflow.
  function automatic logic wraps(input logic [CW-1:0] cnt, input logic [CW-1:0] lim);
    logic [CW-1:0] eff;
    eff = (lim == '0) ? CW'(1) : lim;
    return ({1'b0, cnt} + (CW+1)'(1)) >= {1'b0, eff};
  endfunction

  assign cfg_ready = ~pend_q;
  assign accept    = cfg_valid & cfg_ready;
  assign ch_ok     = (32'(cfg_ch) < NCH);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (run)       state_d = StRun;
        else if (step) state_d = StStep;
      end
      StRun:   if (!run) state_d = StIdle;
      StStep:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign counting = (state_q != StIdle);
  assign to_idle  = counting && (state_d == StIdle);
  // A write landing on the cycle we fall back to idle is applied directly, never left pending.
  assign write_direct = accept && ch_ok && ((state_q == StIdle) || to_idle);
  assign write_pend   = accept && ch_ok && !write_direct;

  always_comb begin
    clk_d    = clk_q;
    tick_d   = '0;
    pend_hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]   = cnt_q[i];
      limit_d[i] = limit_q[i];
      if (counting && ch_en[i]) begin
        if (wraps(cnt_q[i], limit_q[i])) begin
          cnt_d[i]  = '0;
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = 1'b1;
          if (pend_q && (pend_ch_q == 3'(i))) begin
            limit_d[i] = pend_lim_q;
            pend_hit   = 1'b1;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
      if (to_idle && pend_q && (pend_ch_q == 3'(i))) begin
        limit_d[i] = pend_lim_q;
        cnt_d[i]   = '0;
      end
      if (write_direct && (cfg_ch == 3'(i))) begin
        limit_d[i] = cfg_limit;
        cnt_d[i]   = '0;
      end
    end
  end

  always_comb begin
    pend_d     = pend_q;
    pend_ch_d  = pend_ch_q;
    pend_lim_d = pend_lim_q;
    if (pend_q && (pend_hit || to_idle)) pend_d = 1'b0;
    if (write_pend) begin
      pend_d     = 1'b1;
      pend_ch_d  = cfg_ch;
      pend_lim_d = cfg_limit;
    end
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      clk_q      <= '0;
      tick_q     <= '0;
      busy_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_ch_q  <= '0;
      pend_lim_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]   <= '0;
        limit_q[i] <= DefLimit;
      end
    end else begin
      state_q    <= state_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      busy_q     <= (state_d != StIdle);
      pend_q     <= pend_d;
      pend_ch_q  <= pend_ch_d;
      pend_lim_q <= pend_lim_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        limit_q[i] <= limit_d[i];
      end
    end
  end

  assign clkout = clk_q;
  assign tick   = tick_q;
  assign busy   = busy_q;

`ifdef CLKGEN_SCHED_TICKCNT_EN
  logic [15:0] tc_q;

  // Counts alongside tick[0] so tick_cnt and tick update on the same edge.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      tc_q <= '0;
    end else if (accept && (cfg_ch == 3'd0)) begin
      tc_q <= '0;
    end else if (tick_d[0]) begin
      tc_q <= tc_q + 16'd1;
    end
  end

  assign tick_cnt = tc_q;
`else
  assign tick_cnt = '0;
`endif

endmodule
